// File: rtl/rot_ctrl_pkg.sv
// rot_ctrl_pkg: shared constants, FSM state encoding and requester ids for the rotating pixel store controller.
package rot_ctrl_pkg;
    localparam int NIBBLES = 8;
    localparam int SLOT_W  = 3;
    localparam logic [SLOT_W-1:0] PH_LAST = SLOT_W'(NIBBLES - 1);
    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_e;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/rot_register.sv
// rot_register: 8-nibble ring that rotates every cycle; set_data replaces the nibble arriving at the output next cycle.
module rot_register
    import rot_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       set_data_i,
    input  logic [3:0] data_in_i,
    output logic [3:0] data_out_o
);
    logic [NIBBLES-1:0][3:0] ring_q;
    // Element 0 is on the output; element 1 becomes visible next cycle.
    always_ff @(posedge clk) begin
        ring_q <= {ring_q[0], ring_q[NIBBLES-1:2], set_data_i ? data_in_i : ring_q[1]};
    end
    assign data_out_o = ring_q[0];
endmodule

// File: rtl/rot_register_ctrl.sv
// rot_register_ctrl: clears the rotating pixel store after reset and serialises slot reads/writes from two requesters.
module rot_register_ctrl
    import rot_ctrl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid_i,
    input  logic              a_we_i,
    input  logic [SLOT_W-1:0] a_slot_i,
    input  logic [3:0]        a_wdata_i,
    output logic              a_done_o,
    output logic [3:0]        a_rdata_o,
    input  logic              b_valid_i,
    input  logic              b_we_i,
    input  logic [SLOT_W-1:0] b_slot_i,
    input  logic [3:0]        b_wdata_i,
    output logic              b_done_o,
    output logic [3:0]        b_rdata_o,
    output logic              busy_o,
    output logic [3:0]        pix_data_o,
    output logic [SLOT_W-1:0] pix_slot_o
);
    state_e            state_q, state_d;
    port_e             gnt_q, gnt_d, last_q, last_d;
    logic              we_q, we_d;
    logic [SLOT_W-1:0] slot_q, slot_d, ph_q;
    logic [3:0]        wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              pick_b, hit, set_data;
    logic [3:0]        data_in, data_out;

    assign pick_b = b_valid_i && (!a_valid_i || (RR_EN && last_q == PORT_A));
    // A write must land one phase before its slot reaches the output.
    assign hit = we_q ? (ph_q == SLOT_W'(slot_q - 1'b1)) : (ph_q == slot_q);
    assign set_data = rst_n && (state_q == CLEAR || (state_q == WAIT && we_q && hit));
    assign data_in = (state_q == CLEAR) ? 4'h0 : wdata_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        slot_d    = slot_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            CLEAR: state_d = (ph_q == PH_LAST) ? IDLE : CLEAR;
            IDLE: if (a_valid_i || b_valid_i) begin
                gnt_d   = pick_b ? PORT_B : PORT_A;
                last_d  = pick_b ? PORT_B : PORT_A;
                we_d    = pick_b ? b_we_i : a_we_i;
                slot_d  = pick_b ? b_slot_i : a_slot_i;
                wdata_d = pick_b ? b_wdata_i : a_wdata_i;
                state_d = WAIT;
            end
            WAIT: if (hit) begin
                state_d   = DONE;
                a_rdata_d = (!we_q && gnt_q == PORT_A) ? data_out : a_rdata_q;
                b_rdata_d = (!we_q && gnt_q == PORT_B) ? data_out : b_rdata_q;
            end
            DONE: state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            ph_q      <= '0;
            gnt_q     <= PORT_A;
            last_q    <= PORT_B;
            we_q      <= 1'b0;
            slot_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_q + 1'b1;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            slot_q    <= slot_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    rot_register u_rot (
        .clk        (clk),
        .set_data_i (set_data),
        .data_in_i  (data_in),
        .data_out_o (data_out)
    );

    assign busy_o     = (state_q == CLEAR);
    assign a_done_o   = (state_q == DONE) && (gnt_q == PORT_A);
    assign b_done_o   = (state_q == DONE) && (gnt_q == PORT_B);
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
    assign pix_data_o = data_out;
    assign pix_slot_o = ph_q;
endmodule

// File: tb/tb_rot_register_ctrl.sv
// tb_rot_register_ctrl: scoreboard bench for the rotating pixel store controller (round-robin and fixed-priority instances).
module tb_rot_register_ctrl;
    import rot_ctrl_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [SLOT_W-1:0] a_slot = '0, b_slot = '0, pix_slot, pix_slot0;
    logic [3:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, pix_data, a_rdata0, b_rdata0, pix_data0;
    logic a_done, b_done, busy, a_done0, b_done0, busy0;
    int vectors = 0, miscompares = 0;
    logic [3:0] mem [NIBBLES];
    typedef struct packed {logic port; logic we; logic [3:0] rdata;} exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rot_register_ctrl #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid), .a_we_i(a_we), .a_slot_i(a_slot), .a_wdata_i(a_wdata),
        .a_done_o(a_done), .a_rdata_o(a_rdata),
        .b_valid_i(b_valid), .b_we_i(b_we), .b_slot_i(b_slot), .b_wdata_i(b_wdata),
        .b_done_o(b_done), .b_rdata_o(b_rdata),
        .busy_o(busy), .pix_data_o(pix_data), .pix_slot_o(pix_slot)
    );

    rot_register_ctrl #(.RR_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid), .a_we_i(a_we), .a_slot_i(a_slot), .a_wdata_i(a_wdata),
        .a_done_o(a_done0), .a_rdata_o(a_rdata0),
        .b_valid_i(b_valid), .b_we_i(b_we), .b_slot_i(b_slot), .b_wdata_i(b_wdata),
        .b_done_o(b_done0), .b_rdata_o(b_rdata0),
        .busy_o(busy0), .pix_data_o(pix_data0), .pix_slot_o(pix_slot0)
    );

    // Drives one request, pushes its expectation, and waits (bounded) for a done pulse.
    task automatic run_op(input logic port, input logic we, input logic [SLOT_W-1:0] slot, input logic [3:0] wdata,
                          output logic ok, output logic got_port, output logic [3:0] rd, output int set_cnt,
                          output logic [SLOT_W-1:0] set_ph, output logic [SLOT_W-1:0] done_ph);
        ok = 1'b0; got_port = 1'b0; rd = '0; set_cnt = 0; set_ph = '0; done_ph = '0;
        if (port == PORT_A) begin a_valid = 1'b1; a_we = we; a_slot = slot; a_wdata = wdata; end
        else begin b_valid = 1'b1; b_we = we; b_slot = slot; b_wdata = wdata; end
        exp_q.push_back('{port, we, we ? 4'h0 : mem[slot]});
        if (we) mem[slot] = wdata;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (dut.set_data && !busy) begin set_cnt++; set_ph = pix_slot; end
            if (a_done || b_done) begin
                ok = 1'b1; got_port = b_done; rd = b_done ? b_rdata : a_rdata; done_ph = pix_slot;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_reset;
        int cnt = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || a_done !== 1'b0 || b_done !== 1'b0 || a_rdata !== 4'h0 || b_rdata !== 4'h0 || pix_slot !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b a_done=%b b_done=%b a_rdata=%h b_rdata=%h ph=%0d, required 1 0 0 0 0 0",
                     busy, a_done, b_done, a_rdata, b_rdata, pix_slot);
        end
        rst_n = 1'b1;
        while (busy === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
        vectors++;
        if (cnt != 8) begin miscompares++; $display("FAIL busy_cycles: got %0d, required 8", cnt); end
        for (int k = 0; k < NIBBLES; k++) mem[k] = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            vectors++;
            if (pix_data !== mem[pix_slot]) begin
                miscompares++; $display("FAIL clear_slot%0d: got %h, required %h", pix_slot, pix_data, mem[pix_slot]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_slot5;
        logic ok, gp; logic [3:0] rd; int sc; logic [SLOT_W-1:0] sp, dp; exp_t e;
        for (int i = 0; i < 16 && pix_slot !== 3'd2; i++) @(negedge clk);
        run_op(PORT_A, 1'b1, 3'd5, 4'hA, ok, gp, rd, sc, sp, dp);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || gp !== e.port) begin miscompares++; $display("FAIL w5_done: ok=%b port=%b, required ok=1 port=%b", ok, gp, e.port); end
        vectors++;
        if (sc != 1 || sp !== 3'd4) begin miscompares++; $display("FAIL w5_set: count=%0d ph=%0d, required 1 at ph 4", sc, sp); end
        vectors++;
        if (dp !== 3'd5 || pix_data !== 4'hA) begin miscompares++; $display("FAIL w5_done_ph: ph=%0d pix=%h, required ph 5 pix a", dp, pix_data); end
        for (int k = 0; k < NIBBLES; k++) begin
            @(negedge clk);
            vectors++;
            if (pix_data !== mem[pix_slot]) begin
                miscompares++; $display("FAIL w5_slot%0d: got %h, required %h", pix_slot, pix_data, mem[pix_slot]);
            end
        end
    endtask

    task automatic test_write_wrap;
        logic ok, gp; logic [3:0] rd; int sc; logic [SLOT_W-1:0] sp, dp; exp_t e;
        run_op(PORT_A, 1'b1, 3'd0, 4'h3, ok, gp, rd, sc, sp, dp);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || gp !== e.port) begin miscompares++; $display("FAIL w0_done: ok=%b port=%b, required ok=1 port=%b", ok, gp, e.port); end
        vectors++;
        if (sc != 1 || sp !== 3'd7) begin miscompares++; $display("FAIL w0_set: count=%0d ph=%0d, required 1 at ph 7", sc, sp); end
        for (int k = 0; k < NIBBLES; k++) begin
            @(negedge clk);
            vectors++;
            if (pix_data !== mem[pix_slot]) begin
                miscompares++; $display("FAIL w0_slot%0d: got %h, required %h", pix_slot, pix_data, mem[pix_slot]);
            end
        end
    endtask

    task automatic test_read_b;
        logic ok, gp; logic [3:0] rd; int sc; logic [SLOT_W-1:0] sp, dp; exp_t e;
        run_op(PORT_B, 1'b0, 3'd5, 4'h0, ok, gp, rd, sc, sp, dp);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || gp !== e.port || rd !== e.rdata) begin
            miscompares++; $display("FAIL b_read5: ok=%b port=%b data=%h, required ok=1 port=%b data=%h", ok, gp, rd, e.port, e.rdata);
        end
        vectors++;
        if (sc != 0) begin miscompares++; $display("FAIL b_read5_set: count=%0d, required 0", sc); end
    endtask

    task automatic test_arbitration;
        int n = 0, a0 = 0, b0 = 0; exp_t e;
        a_valid = 1'b1; a_we = 1'b0; a_slot = 3'd5;
        b_valid = 1'b1; b_we = 1'b0; b_slot = 3'd0;
        for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? '{PORT_A, 1'b0, mem[5]} : '{PORT_B, 1'b0, mem[0]});
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            a0 += int'(a_done0); b0 += int'(b_done0);
            if (a_done || b_done) begin
                e = exp_q.pop_front();
                n++;
                vectors++;
                if (b_done !== e.port || a_done === b_done || (b_done ? b_rdata : a_rdata) !== e.rdata) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: a_done=%b b_done=%b data=%h, required port=%b data=%h",
                             n, a_done, b_done, b_done ? b_rdata : a_rdata, e.port, e.rdata);
                end
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); a0 += int'(a_done0); b0 += int'(b_done0); end
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL rr_count: got %0d grants, required 4", n); exp_q.delete(); end
        vectors++;
        if (b0 != 0 || a0 < 2) begin miscompares++; $display("FAIL fixed_prio: a=%0d b=%0d, required a>=2 b=0", a0, b0); end
    endtask

    task automatic test_back_to_back;
        logic ok, gp, p, w; logic [3:0] rd, wd; int sc; logic [SLOT_W-1:0] sp, dp, s; exp_t e;
        for (int k = 0; k < 10; k++) begin
            p  = (k < 2) ? logic'(k) : logic'($urandom_range(0, 1));
            w  = (k < 2) ? (k == 0) : logic'($urandom_range(0, 1));
            s  = (k < 2) ? 3'd6 : SLOT_W'($urandom_range(0, NIBBLES - 1));
            wd = (k == 0) ? 4'h5 : 4'($urandom_range(0, 15));
            run_op(p, w, s, wd, ok, gp, rd, sc, sp, dp);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || gp !== e.port || (!e.we && rd !== e.rdata) || sc != int'(e.we)) begin
                miscompares++;
                $display("FAIL b2b_op%0d: ok=%b port=%b data=%h sets=%0d, required port=%b we=%b data=%h",
                         k, ok, gp, rd, sc, e.port, e.we, e.rdata);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        int cnt = 0, dn = 0;
        @(negedge clk);
        for (int i = 0; i < 16 && pix_slot !== 3'd3; i++) @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_slot = 3'd3; a_wdata = 4'h7;
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 16 && pix_slot !== 3'd2; i++) begin dn += int'(a_done); @(negedge clk); end
        vectors++;
        if (dut.set_data !== 1'b1) begin miscompares++; $display("FAIL pre_reset_hit: set_data=%b, required 1", dut.set_data); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dut.set_data !== 1'b0) begin miscompares++; $display("FAIL reset_gate: set_data=%b, required 0", dut.set_data); end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (busy !== 1'b1 || pix_slot !== '0 || a_rdata !== 4'h0) begin
            miscompares++; $display("FAIL mid_reset_state: busy=%b ph=%0d a_rdata=%h, required 1 0 0", busy, pix_slot, a_rdata);
        end
        while (busy === 1'b1 && cnt < 20) begin dn += int'(a_done); cnt++; @(negedge clk); end
        vectors++;
        if (cnt != 8 || dn != 0) begin miscompares++; $display("FAIL mid_reset_clear: busy=%0d dones=%0d, required 8 0", cnt, dn); end
        for (int k = 0; k < NIBBLES; k++) mem[k] = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            vectors++;
            if (pix_data !== mem[pix_slot] || a_done !== 1'b0) begin
                miscompares++; $display("FAIL reclear_slot%0d: got %h done=%b, required %h 0", pix_slot, pix_data, a_done, mem[pix_slot]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write_slot5();
        test_write_wrap();
        test_read_b();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end
endmodule
